// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    LOAD
  } imem_state_t;

  localparam logic [31:0] NOP_INSTR      = 32'h00000013;
  localparam int          BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_byte_store.sv
// Byte-addressed instruction storage: one byte write port, combinational aligned 4-byte read.
module imem_byte_store
  import imem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12
) (
  input  logic                     clk_i,
  input  logic                     wr_en_i,
  input  logic [ADDRESS_WIDTH-1:0] wr_addr_i,
  input  logic [7:0]               wr_data_i,
  input  logic [ADDRESS_WIDTH-3:0] rd_waddr_i,
  output logic [31:0]              rd_word_o
);

  localparam int DEPTH = 2 ** ADDRESS_WIDTH;

  logic [7:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  // The read address is word-aligned, so the four byte lanes never cross the top of memory.
  always_comb begin
    rd_word_o = '0;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      rd_word_o[8*b +: 8] = mem_q[{rd_waddr_i, 2'(b)}];
    end
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: valid/ready fetch with LATENCY-cycle response and a byte-serial load port.
// Define IMEM_MISALIGN_CHECK_EN to flag misaligned fetches with resp_err and a NOP instruction.
module imem_responder
  import imem_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 12,
  parameter int DATA_WIDTH    = 32,
  parameter int LATENCY       = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [ADDRESS_WIDTH-1:0] req_addr,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [DATA_WIDTH-1:0]    resp_instr,
  output logic                     resp_err,
  input  logic                     load_mode,
  input  logic                     load_valid,
  input  logic [7:0]               load_byte,
  output logic [ADDRESS_WIDTH-1:0] load_count
);

  localparam int         AW       = ADDRESS_WIDTH;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  imem_state_t           state_q;
  logic [3:0]            cnt_q;
  logic [AW-1:0]         addr_q;
  logic [AW-1:0]         load_count_q;
  logic                  resp_valid_q;
  logic                  resp_err_q;
  logic [DATA_WIDTH-1:0] resp_instr_q;

  logic [AW-1:0]         rd_addr_d;
  logic [31:0]           rd_word;
  logic [DATA_WIDTH-1:0] instr_d;
  logic                  err_d;
  logic                  wr_en;

  assign wr_en     = (state_q == LOAD) && load_mode && load_valid;
  // With LATENCY=1 the response is captured on the accept edge, so read the live request address.
  assign rd_addr_d = (state_q == IDLE) ? req_addr : addr_q;

  imem_byte_store #(
    .ADDRESS_WIDTH(AW)
  ) u_store (
    .clk_i     (clk),
    .wr_en_i   (wr_en),
    .wr_addr_i (load_count_q),
    .wr_data_i (load_byte),
    .rd_waddr_i(rd_addr_d[AW-1:2]),
    .rd_word_o (rd_word)
  );

`ifdef IMEM_MISALIGN_CHECK_EN
  always_comb begin
    err_d   = |rd_addr_d[1:0];
    instr_d = err_d ? NOP_INSTR : rd_word;
  end
`else
  logic addr_lsb_unused;
  assign addr_lsb_unused = ^rd_addr_d[1:0];

  always_comb begin
    err_d   = 1'b0;
    instr_d = rd_word;
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      load_count_q <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_instr_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (load_mode) begin
            state_q      <= LOAD;
            load_count_q <= '0;
          end else if (req_valid) begin
            addr_q <= req_addr;
            cnt_q  <= CNT_INIT;
            if (LATENCY == 1) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_instr_q <= instr_d;
              resp_err_q   <= err_d;
            end else begin
              state_q <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt_q == 4'd1) begin
            state_q      <= RESP;
            cnt_q        <= '0;
            resp_valid_q <= 1'b1;
            resp_instr_q <= instr_d;
            resp_err_q   <= err_d;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (resp_ready) begin
            state_q      <= IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
          end
        end
        LOAD: begin
          if (!load_mode) begin
            state_q <= IDLE;
          end else if (load_valid) begin
            load_count_q <= load_count_q + AW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready  = (state_q == IDLE) && !rst;
  assign resp_valid = resp_valid_q;
  assign resp_instr = resp_instr_q;
  assign resp_err   = resp_err_q;
  assign load_count = load_count_q;

endmodule

// File: tb/tb_imem_responder.sv
// Self-checking bench for imem_responder: fetch vector table with a response scoreboard plus load/reset corner sequences.
module tb_imem_responder;

  localparam int AW    = 12;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AW;

`ifdef IMEM_MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_instr;
  logic          resp_err;
  logic          load_mode;
  logic          load_valid;
  logic [7:0]    load_byte;
  logic [AW-1:0] load_count;

  always #5 clk = ~clk;

  imem_responder #(
    .ADDRESS_WIDTH(AW),
    .DATA_WIDTH   (32),
    .LATENCY      (LAT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_instr(resp_instr),
    .resp_err  (resp_err),
    .load_mode (load_mode),
    .load_valid(load_valid),
    .load_byte (load_byte),
    .load_count(load_count)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   instr;
    logic          err;
    int            stall;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic        err;
  } exp_t;

  exp_t       sb_q[$];
  logic [7:0] ld_q[$];
  logic [7:0] model [DEPTH];
  int         n_vec = 0;
  int         n_err = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_word(input logic [AW-1:0] addr);
    logic [AW-1:0] a;
    a = {addr[AW-1:2], 2'b00};
    return {model[a + AW'(3)], model[a + AW'(2)], model[a + AW'(1)], model[a]};
  endfunction

  // Loads ld_q, then exits LOAD with a stray load_valid byte that must not be written.
  task automatic load_prog(input string nm);
    int cnt;
    cnt        = 0;
    load_mode  = 1'b1;
    load_valid = 1'b0;
    step();
    foreach (ld_q[i]) begin
      load_valid = 1'b1;
      load_byte  = ld_q[i];
      step();
      model[cnt % DEPTH] = ld_q[i];
      cnt++;
    end
    load_mode  = 1'b0;
    load_valid = 1'b1;
    load_byte  = 8'hEE;
    step();
    load_valid = 1'b0;
    check({nm, "/load_count"}, 32'(load_count), 32'(cnt % DEPTH));
  endtask

  task automatic do_fetch(input string nm, input logic [AW-1:0] addr, input exp_t e, input int stall);
    int   lat;
    exp_t want;
    req_valid = 1'b1;
    req_addr  = addr;
    check({nm, "/req_ready"}, 32'(req_ready), 32'd1);
    sb_q.push_back(e);
    step();
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat <= 16) begin
      step();
      lat++;
    end
    check({nm, "/latency"}, 32'(lat), 32'(LAT));
    if (resp_valid) begin
      want = sb_q.pop_front();
      check({nm, "/instr"}, resp_instr, want.instr);
      check({nm, "/err"}, 32'(resp_err), 32'(want.err));
      for (int s = 0; s < stall; s++) begin
        step();
        check({nm, "/stall_valid"}, 32'(resp_valid), 32'd1);
        check({nm, "/stall_instr"}, resp_instr, want.instr);
        check({nm, "/stall_req_ready"}, 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
      step();
      resp_ready = 1'b0;
      check({nm, "/drain_valid"}, 32'(resp_valid), 32'd0);
      check({nm, "/drain_req_ready"}, 32'(req_ready), 32'd1);
      check({nm, "/drain_err"}, 32'(resp_err), 32'd0);
    end else begin
      void'(sb_q.pop_front());
    end
  endtask

  task automatic expect_no_resp(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (resp_valid) seen++;
    end
    check({nm, "/no_resp"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[7];
    exp_t       e;
    logic [7:0] prog[16];

    prog = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00,
             8'h33, 8'h86, 8'hB5, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
    vecs[0] = '{12'h000, 32'h00A00513, 1'b0, 0};
    vecs[1] = '{12'h004, 32'h00B00593, 1'b0, 0};
    vecs[2] = '{12'h008, 32'h00B58633, 1'b0, 1};
    vecs[3] = '{12'h00C, 32'h0000006F, 1'b0, 5};
    vecs[4] = '{12'h006, MIS_EN ? 32'h00000013 : 32'h00B00593, MIS_EN, 0};
    vecs[5] = '{12'h00B, MIS_EN ? 32'h00000013 : 32'h00B58633, MIS_EN, 2};
    vecs[6] = '{12'h001, MIS_EN ? 32'h00000013 : 32'h00A00513, MIS_EN, 0};

    rst        = 1'b1;
    req_valid  = 1'b0;
    req_addr   = '0;
    resp_ready = 1'b0;
    load_mode  = 1'b0;
    load_valid = 1'b0;
    load_byte  = '0;
    #1;
    check("reset/req_ready_in_reset", 32'(req_ready), 32'd0);
    step();
    step();
    check("reset/resp_valid", 32'(resp_valid), 32'd0);
    check("reset/resp_instr", resp_instr, 32'd0);
    check("reset/resp_err", 32'(resp_err), 32'd0);
    check("reset/load_count", 32'(load_count), 32'd0);
    rst = 1'b0;
    #1;
    check("reset/req_ready_idle", 32'(req_ready), 32'd1);

    // Full program, then a shorter reload that must restart the count at zero.
    ld_q.delete();
    foreach (prog[i]) ld_q.push_back(prog[i]);
    load_prog("load16");
    ld_q.delete();
    for (int i = 0; i < 8; i++) ld_q.push_back(prog[i]);
    load_prog("load8");

    foreach (vecs[i]) begin
      e.instr = vecs[i].instr;
      e.err   = vecs[i].err;
      do_fetch($sformatf("vec%0d", i), vecs[i].addr, e, vecs[i].stall);
    end

    // Reset while the request is waiting: it must vanish without a response.
    req_valid = 1'b1;
    req_addr  = 12'h004;
    step();
    req_valid = 1'b0;
    check("rstwait/in_wait_valid", 32'(resp_valid), 32'd0);
    check("rstwait/in_wait_req_ready", 32'(req_ready), 32'd0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("rstwait/req_ready", 32'(req_ready), 32'd1);
    check("rstwait/load_count", 32'(load_count), 32'd0);
    expect_no_resp("rstwait", 6);
    e.instr = model_word(12'h004);
    e.err   = 1'b0;
    do_fetch("rstwait_refetch", 12'h004, e, 0);

    // load_mode wins over a same-cycle request.
    load_mode = 1'b1;
    req_valid = 1'b1;
    req_addr  = 12'h000;
    check("collide/req_ready", 32'(req_ready), 32'd1);
    step();
    check("collide/in_load_req_ready", 32'(req_ready), 32'd0);
    load_mode = 1'b0;
    req_valid = 1'b0;
    step();
    check("collide/back_idle", 32'(req_ready), 32'd1);
    check("collide/load_count", 32'(load_count), 32'd0);
    expect_no_resp("collide", 6);

    // One byte past full memory: the count wraps and byte 4097 lands at address 0.
    ld_q.delete();
    for (int i = 0; i <= DEPTH; i++) ld_q.push_back(8'((i * 13 + (i >> 8) + 1) & 255));
    load_prog("wrap");
    e.instr = model_word(12'h000);
    e.err   = 1'b0;
    check("wrap/model_byte0", 32'(model[0]), 32'h11);
    do_fetch("wrap_fetch0", 12'h000, e, 0);
    e.instr = model_word(12'hFFC);
    do_fetch("wrap_fetch_top", 12'hFFC, e, 0);

    check("scoreboard/drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
